// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, the run/halt state and the retired count.
// Each instruction steps FETCH -> EXEC, with an added MEMWAIT stage for LW/SW.
module instr_sequencer #(
    parameter int         PC_W    = 8,
    parameter int         OFF_W   = 5,
    parameter int         MEM_TO  = 15,
    parameter int         CNT_W   = 16,
    parameter logic [3:0] HALT_OP = 4'b1110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             branch,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             reg_we_en,
    output logic             mem_req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] OP_LW = 4'b1100;
    localparam logic [3:0] OP_SW = 4'b1011;
    localparam int         WC_W  = $clog2(MEM_TO + 1);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic [WC_W-1:0]   wcnt;
    logic [PC_W-1:0]   off_ext;
    logic              is_mem;
    logic              retire, pc_inc, pc_br, set_err, clr_run;

    assign off_ext = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);

    always_comb begin
        state_nx  = state;
        fetch_en  = 1'b0;
        reg_we_en = 1'b0;
        mem_req   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        retire    = 1'b0;
        pc_inc    = 1'b0;
        pc_br     = 1'b0;
        set_err   = 1'b0;
        clr_run   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    clr_run  = 1'b1;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                fetch_en = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (opcode == HALT_OP) begin
                    state_nx = DONE;
                end else if (is_mem) begin
                    state_nx = MEMWAIT;
                end else begin
                    reg_we_en = 1'b1;
                    retire    = 1'b1;
                    pc_br     = branch;
                    pc_inc    = !branch;
                    state_nx  = FETCH;
                end
            end
            MEMWAIT: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                // An ack in the last allowed cycle beats the timeout.
                if (mem_ready) begin
                    reg_we_en = (op_q == OP_LW);
                    retire    = 1'b1;
                    pc_inc    = 1'b1;
                    state_nx  = FETCH;
                end else if (wcnt == WC_W'(MEM_TO - 1)) begin
                    set_err  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = FETCH;
                    clr_run  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            retired <= '0;
            err     <= 1'b0;
            op_q    <= '0;
            wcnt    <= '0;
        end else begin
            state <= state_nx;
            if (clr_run) begin
                pc      <= '0;
                retired <= '0;
                err     <= 1'b0;
            end
            if (pc_inc) pc <= pc + PC_W'(1);
            if (pc_br)  pc <= pc + off_ext;
            // Saturating count: holds at all-ones.
            if (retire && (retired != '1)) retired <= retired + CNT_W'(1);
            if (set_err) err <= 1'b1;
            if (state == EXEC) op_q <= opcode;
            wcnt <= (state == MEMWAIT) ? wcnt + WC_W'(1) : '0;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random instruction streams checked against
// an instruction-level model (pc, retired count, error flag, expected per-cycle strobes).
module tb_instr_sequencer;
    localparam int PC_W   = 8;
    localparam int OFF_W  = 5;
    localparam int MEM_TO = 15;
    localparam int CNT_W  = 4;
    localparam int RET_MAX = (1 << CNT_W) - 1;
    localparam logic [3:0] ADD = 4'b0000, LW = 4'b1100, SW = 4'b1011, HALT = 4'b1110;

    logic             clk = 1'b0;
    logic             reset, start, branch, mem_ready;
    logic [3:0]       opcode;
    logic [OFF_W-1:0] branch_off;
    logic [PC_W-1:0]  pc;
    logic             fetch_en, reg_we_en, mem_req, busy, done, err;
    logic [CNT_W-1:0] retired;

    instr_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .MEM_TO(MEM_TO), .CNT_W(CNT_W), .HALT_OP(HALT)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch(branch),
        .branch_off(branch_off), .mem_ready(mem_ready), .pc(pc), .fetch_en(fetch_en),
        .reg_we_en(reg_we_en), .mem_req(mem_req), .busy(busy), .done(done), .err(err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mpc;
    int         mret;
    logic       merr;
    bit         ended;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit f, input bit b, input bit d);
        chk({tag, "_fetch_en"}, 32'(fetch_en), 32'(f));
        chk({tag, "_busy"},     32'(busy),     32'(b));
        chk({tag, "_done"},     32'(done),     32'(d));
        chk({tag, "_pc"},       32'(pc),       32'(mpc));
        chk({tag, "_retired"},  32'(retired),  32'(mret));
        chk({tag, "_err"},      32'(err),      32'(merr));
    endtask

    task automatic retire_one();
        if (mret < RET_MAX) mret++;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        mpc = 8'h00; mret = 0; merr = 1'b0;
    endtask

    // One instruction from its FETCH cycle; lat = MEMWAIT cycle carrying mem_ready, 0 = never.
    task automatic exec_instr(input logic [3:0] op, input bit br, input logic [4:0] off,
                              input int lat, output bit fin);
        bit mem_op, halt_op, got;
        fin = 1'b0;
        mem_op  = (op == LW) || (op == SW);
        halt_op = (op == HALT);
        @(negedge clk);
        start = 1'($urandom); branch = 1'($urandom); branch_off = 5'($urandom);
        opcode = 4'($urandom); mem_ready = 1'b0;
        #1;
        check_state("fetch", 1, 1, 0);
        chk("fetch_we", 32'(reg_we_en), 32'(0));
        chk("fetch_mreq", 32'(mem_req), 32'(0));
        @(negedge clk);
        opcode = op; branch = br; branch_off = off; start = 1'($urandom);
        #1;
        check_state("exec", 0, 1, 0);
        chk("exec_we", 32'(reg_we_en), 32'(!(mem_op || halt_op)));
        chk("exec_mreq", 32'(mem_req), 32'(0));
        if (halt_op) begin
            fin = 1'b1;
        end else if (!mem_op) begin
            mpc = br ? mpc + {{3{off[4]}}, off} : mpc + 8'd1;
            retire_one();
        end else begin
            got = 1'b0;
            for (int i = 1; i <= MEM_TO; i++) begin
                @(negedge clk);
                opcode = 4'($urandom); branch = 1'($urandom); start = 1'($urandom);
                mem_ready = (i == lat);
                #1;
                check_state("memwait", 0, 1, 0);
                chk("memwait_mreq", 32'(mem_req), 32'(1));
                chk("memwait_we", 32'(reg_we_en), 32'(mem_ready && (op == LW)));
                if (i == lat) begin
                    got = 1'b1;
                    break;
                end
            end
            if (got) begin
                mpc = mpc + 8'd1;
                retire_one();
            end else begin
                merr = 1'b1;
                fin = 1'b1;
            end
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        #1;
        check_state("done", 0, 0, 1);
        chk("done_mreq", 32'(mem_req), 32'(0));
        chk("done_we", 32'(reg_we_en), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] op;
        reset = 1'b1; start = 1'b0; branch = 1'b0; mem_ready = 1'b0;
        opcode = 4'h0; branch_off = '0;
        mpc = 8'h00; mret = 0; merr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_state("reset", 0, 0, 0);
        chk("reset_mreq", 32'(mem_req), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_state("idle", 0, 0, 0);

        // ADD, ADD, HALT
        do_start();
        exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(HALT, 0, 5'd0, 0, ended);
        check_done();
        chk("prog1_retired", 32'(retired), 32'(2));

        // Branches forward and backward around pc=0x10
        do_start();
        exec_instr(ADD, 1, 5'd15, 0, ended);
        exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(ADD, 1, 5'b11110, 0, ended);
        exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(ADD, 1, 5'd3, 0, ended);
        exec_instr(HALT, 0, 5'd0, 0, ended);
        check_done();
        chk("branch_pc", 32'(pc), 32'(8'h13));

        // LW then SW at pc=4,5 with ack in third wait cycle
        do_start();
        repeat (4) exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(LW, 0, 5'd0, 3, ended);
        exec_instr(SW, 0, 5'd0, 3, ended);
        exec_instr(LW, 0, 5'd0, 1, ended);
        exec_instr(HALT, 0, 5'd0, 0, ended);
        check_done();

        // LW timeout at pc=4
        do_start();
        repeat (4) exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(LW, 0, 5'd0, 0, ended);
        check_done();
        chk("timeout_err", 32'(err), 32'(1));
        chk("timeout_pc", 32'(pc), 32'(4));

        // Ack on the last allowed cycle, then pc wrap at 0xFF
        do_start();
        exec_instr(SW, 0, 5'd0, MEM_TO, ended);
        exec_instr(ADD, 1, 5'b11110, 0, ended);
        exec_instr(ADD, 0, 5'd0, 0, ended);
        chk("wrap_model_pc", 32'(mpc), 32'(8'h00));
        exec_instr(HALT, 0, 5'd0, 0, ended);
        check_done();

        // Retired saturation
        do_start();
        repeat (RET_MAX + 3) exec_instr(ADD, 0, 5'd0, 0, ended);
        exec_instr(HALT, 0, 5'd0, 0, ended);
        check_done();
        chk("sat_retired", 32'(retired), 32'(RET_MAX));

        // Reset while in MEMWAIT
        do_start();
        exec_instr(ADD, 0, 5'd0, 0, ended);
        @(negedge clk); start = 1'b0;
        @(negedge clk); opcode = LW; branch = 1'b0;
        @(negedge clk); mem_ready = 1'b0;
        #1;
        chk("pre_reset_mreq", 32'(mem_req), 32'(1));
        reset = 1'b1;
        mpc = 8'h00; mret = 0; merr = 1'b0;
        @(negedge clk);
        #1;
        check_state("mw_reset", 0, 0, 0);
        chk("mw_reset_mreq", 32'(mem_req), 32'(0));
        chk("mw_reset_we", 32'(reg_we_en), 32'(0));
        reset = 1'b0;

        // Random programs
        for (int p = 0; p < 30; p++) begin
            do_start();
            n = $urandom_range(1, 20);
            ended = 1'b0;
            for (int k = 0; k < n && !ended; k++) begin
                op = 4'($urandom);
                if (op == HALT) op = ADD;
                exec_instr(op, 1'($urandom), 5'($urandom),
                           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MEM_TO), ended);
            end
            if (!ended) exec_instr(HALT, 0, 5'd0, 0, ended);
            check_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
